// File: rtl/dfp_norm_round128.sv
// Decimal floating-point normalise-and-round stage: left-justifies a 2*NDIG-digit BCD product
// one digit per cycle, then rounds it to NDIG digits with the selected rounding mode.
module dfp_norm_round128 #(
  parameter int NDIG  = 34,
  parameter int EMAXB = 12287
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              ld,
  input  logic [2:0]        rm,
  input  logic              sign_i,
  input  logic [15:0]       exp_i,
  input  logic [8*NDIG-1:0] sig_i,
  output logic              busy,
  output logic              done,
  output logic              sign_o,
  output logic [15:0]       exp_o,
  output logic [4*NDIG-1:0] sig_o,
  output logic              inexact,
  output logic              overflow,
  output logic              underflow
);

  localparam int WW = 8 * NDIG;
  localparam int OW = 4 * NDIG;
  localparam int CW = $clog2(NDIG + 1);
  localparam logic signed [16:0] EMAX_S = 17'(EMAXB);

  typedef enum logic [1:0] {
    S_IDLE,
    S_SHIFT,
    S_ROUND,
    S_DONE
  } state_t;

  state_t                state_q, state_d;
  logic [2:0]            rm_q, rm_d;
  logic                  sign_q, sign_d;
  logic [15:0]           exp_q, exp_d;
  logic [WW-1:0]         work_q, work_d;
  logic [CW-1:0]         cnt_q, cnt_d;

  logic                  res_sign_q, res_sign_d;
  logic [15:0]           res_exp_q, res_exp_d;
  logic [OW-1:0]         res_sig_q, res_sig_d;
  logic                  ix_q, ix_d;
  logic                  ov_q, ov_d;
  logic                  uf_q, uf_d;

  logic [OW-1:0]         keep;
  logic [OW-1:0]         inc_sig;
  logic [3:0]            rdig;
  logic [3:0]            dig;
  logic                  sticky;
  logic                  rinexact;
  logic                  inc;
  logic                  carry;
  logic signed [16:0]    exp_base;
  logic signed [16:0]    exp_adj;
  logic signed [16:0]    exp_fin;

  // Rounding datapath, evaluated on the normalised working significand.
  always_comb begin
    // NOTE: every variable gets a default before any branch so no latch is inferred.
    keep     = work_q[WW-1 -: OW];
    rdig     = work_q[OW-1 -: 4];
    sticky   = |work_q[OW-5:0];
    rinexact = (rdig != 4'd0) | sticky;
    inc      = 1'b0;
    inc_sig  = '0;
    dig      = '0;

    case (rm_q)
      3'd1:    inc = 1'b0;
      3'd2:    inc = rinexact & ~sign_q;
      3'd3:    inc = rinexact & sign_q;
      3'd4:    inc = (rdig >= 4'd5);
      default: inc = (rdig > 4'd5) || ((rdig == 4'd5) && (sticky || keep[0]));
    endcase

    // Ripple decimal +1: nines roll to zero while the carry keeps propagating.
    carry = inc;
    for (int i = 0; i < NDIG; i++) begin
      dig = keep[4*i +: 4];
      if (carry && (dig == 4'd9)) begin
        inc_sig[4*i +: 4] = 4'd0;
      end else if (carry) begin
        inc_sig[4*i +: 4] = dig + 4'd1;
        carry             = 1'b0;
      end else begin
        inc_sig[4*i +: 4] = dig;
      end
    end
    if (carry) begin
      inc_sig = {4'h1, {(OW-4){1'b0}}};
    end

    exp_base = {exp_q[15], exp_q};
    exp_adj  = 17'(NDIG) - 17'(cnt_q);
    exp_fin  = exp_base + exp_adj + 17'(carry);
  end

  always_comb begin
    state_d    = state_q;
    rm_d       = rm_q;
    sign_d     = sign_q;
    exp_d      = exp_q;
    work_d     = work_q;
    cnt_d      = cnt_q;
    res_sign_d = res_sign_q;
    res_exp_d  = res_exp_q;
    res_sig_d  = res_sig_q;
    ix_d       = ix_q;
    ov_d       = ov_q;
    uf_d       = uf_q;

    case (state_q)
      S_IDLE, S_DONE: begin
        if (ld) begin
          rm_d    = rm;
          sign_d  = sign_i;
          exp_d   = exp_i;
          work_d  = sig_i;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        if ((work_q[WW-1 -: 4] == 4'd0) && (cnt_q < CW'(NDIG))) begin
          work_d = {work_q[WW-5:0], 4'h0};
          cnt_d  = cnt_q + CW'(1);
        end else begin
          state_d = S_ROUND;
        end
      end
      S_ROUND: begin
        res_sign_d = sign_q;
        res_exp_d  = exp_fin[15:0];
        res_sig_d  = inc_sig;
        ix_d       = rinexact;
        ov_d       = (exp_fin > EMAX_S);
        uf_d       = exp_fin[16];
        state_d    = S_DONE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      rm_q       <= '0;
      sign_q     <= 1'b0;
      exp_q      <= '0;
      work_q     <= '0;
      cnt_q      <= '0;
      res_sign_q <= 1'b0;
      res_exp_q  <= '0;
      res_sig_q  <= '0;
      ix_q       <= 1'b0;
      ov_q       <= 1'b0;
      uf_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments keep every register sampling pre-edge values.
      state_q    <= state_d;
      rm_q       <= rm_d;
      sign_q     <= sign_d;
      exp_q      <= exp_d;
      work_q     <= work_d;
      cnt_q      <= cnt_d;
      res_sign_q <= res_sign_d;
      res_exp_q  <= res_exp_d;
      res_sig_q  <= res_sig_d;
      ix_q       <= ix_d;
      ov_q       <= ov_d;
      uf_q       <= uf_d;
    end
  end

  assign busy      = (state_q == S_SHIFT) || (state_q == S_ROUND);
  assign done      = (state_q == S_DONE);
  assign sign_o    = res_sign_q;
  assign exp_o     = res_exp_q;
  assign sig_o     = res_sig_q;
  assign inexact   = ix_q;
  assign overflow  = ov_q;
  assign underflow = uf_q;

endmodule

// File: tb/tb_dfp_norm_round128.sv
// Directed bench for dfp_norm_round128: hand-computed results, latencies, reset abort and ld handling.
module tb_dfp_norm_round128;

  logic         clk = 1'b0;
  logic         rst;
  logic         ld;
  logic [2:0]   rm;
  logic         sign_i;
  logic [15:0]  exp_i;
  logic [271:0] sig_i;
  logic         busy, done, sign_o, inexact, overflow, underflow;
  logic [15:0]  exp_o;
  logic [135:0] sig_o;

  int n_vec = 0;
  int n_err = 0;

  dfp_norm_round128 #(.NDIG(34), .EMAXB(12287)) dut (
    .clk(clk), .rst(rst), .ld(ld), .rm(rm), .sign_i(sign_i), .exp_i(exp_i),
    .sig_i(sig_i), .busy(busy), .done(done), .sign_o(sign_o), .exp_o(exp_o),
    .sig_o(sig_o), .inexact(inexact), .overflow(overflow), .underflow(underflow)
  );

  always #5 clk = ~clk;

  localparam logic [271:0] THREES = {68{4'h3}};
  localparam logic [271:0] NINES  = {68{4'h9}};

  // {sign, exp, inexact, overflow, underflow, sig}
  function automatic logic [155:0] mk(input logic s, input logic [15:0] e, input logic ix,
                                      input logic ov, input logic uf, input logic [135:0] sg);
    return {s, e, ix, ov, uf, sg};
  endfunction

  function automatic logic [155:0] observed();
    return {sign_o, exp_o, inexact, overflow, underflow, sig_o};
  endfunction

  task automatic launch(input logic [2:0] m, input logic s, input logic [15:0] e, input logic [271:0] sg);
    @(negedge clk);
    rm = m; sign_i = s; exp_i = e; sig_i = sg; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
  endtask

  // Counts cycles from the ld edge (which counts as 1) up to the cycle where done is seen.
  task automatic wait_done(input int start, output int cyc);
    cyc = start;
    while (!done && cyc < 64) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; ld = 1'b0; rm = '0; sign_i = 1'b0; exp_i = '0; sig_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL reset_ctrl: got busy/done %b want 00", {busy, done});
    end
    n_vec++;
    if (observed() !== '0) begin
      n_err++; $display("FAIL reset_data: got %h want 0", observed());
    end
  endtask

  task automatic test_max_shift();
    int cyc;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd6176, 272'h14);
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 37) begin n_err++; $display("FAIL cap34 latency: got %0d want 37", cyc); end
    want = mk(1'b0, 16'd6176, 1'b0, 1'b0, 1'b0, 136'h14);
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL cap34: got %h want %h", observed(), want); end

    launch(3'd3, 1'b1, 16'd100, '0);
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 37) begin n_err++; $display("FAIL zero latency: got %0d want 37", cyc); end
    want = mk(1'b1, 16'd100, 1'b0, 1'b0, 1'b0, '0);
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL zero: got %h want %h", observed(), want); end

    // Seven leading zero digits: 7 shifts, keep = 34 twos, R = 2 with sticky set.
    launch(3'd0, 1'b0, 16'd1000, {{7{4'h0}}, {61{4'h2}}});
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL shift7 latency: got %0d want 10", cyc); end
    want = mk(1'b0, 16'd1027, 1'b1, 1'b0, 1'b0, {34{4'h2}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL shift7: got %h want %h", observed(), want); end
  endtask

  task automatic test_round_modes();
    int cyc;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd6000, THREES);
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 3) begin n_err++; $display("FAIL rne3 latency: got %0d want 3", cyc); end
    want = mk(1'b0, 16'd6034, 1'b1, 1'b0, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rne3: got %h want %h", observed(), want); end

    launch(3'd2, 1'b0, 16'd6000, THREES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'd6034, 1'b1, 1'b0, 1'b0, {{33{4'h3}}, 4'h4});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rtp3: got %h want %h", observed(), want); end

    launch(3'd3, 1'b1, 16'd6000, THREES);
    wait_done(1, cyc);
    want = mk(1'b1, 16'd6034, 1'b1, 1'b0, 1'b0, {{33{4'h3}}, 4'h4});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rtm3: got %h want %h", observed(), want); end

    launch(3'd2, 1'b1, 16'd6000, THREES);
    wait_done(1, cyc);
    want = mk(1'b1, 16'd6034, 1'b1, 1'b0, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rtp_neg: got %h want %h", observed(), want); end

    launch(3'd0, 1'b0, 16'd6000, NINES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'd6035, 1'b1, 1'b0, 1'b0, {4'h1, 132'h0});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL carry9: got %h want %h", observed(), want); end

    launch(3'd1, 1'b0, 16'd6000, NINES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'd6034, 1'b1, 1'b0, 1'b0, {34{4'h9}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rtz9: got %h want %h", observed(), want); end

    // Exact ties: R = 5, sticky clear.
    launch(3'd0, 1'b0, 16'd0, {4'h1, {32{4'h0}}, 4'h2, 4'h5, {33{4'h0}}});
    wait_done(1, cyc);
    want = mk(1'b0, 16'd34, 1'b1, 1'b0, 1'b0, {4'h1, {32{4'h0}}, 4'h2});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rne_tie_even: got %h want %h", observed(), want); end

    launch(3'd0, 1'b0, 16'd0, {4'h1, {32{4'h0}}, 4'h3, 4'h5, {33{4'h0}}});
    wait_done(1, cyc);
    want = mk(1'b0, 16'd34, 1'b1, 1'b0, 1'b0, {4'h1, {32{4'h0}}, 4'h4});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rne_tie_odd: got %h want %h", observed(), want); end

    launch(3'd4, 1'b0, 16'd0, {4'h1, {32{4'h0}}, 4'h2, 4'h5, {33{4'h0}}});
    wait_done(1, cyc);
    want = mk(1'b0, 16'd34, 1'b1, 1'b0, 1'b0, {4'h1, {32{4'h0}}, 4'h3});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rmm_tie: got %h want %h", observed(), want); end

    launch(3'd7, 1'b0, 16'd0, {4'h1, {32{4'h0}}, 4'h2, 4'h5, {33{4'h0}}});
    wait_done(1, cyc);
    want = mk(1'b0, 16'd34, 1'b1, 1'b0, 1'b0, {4'h1, {32{4'h0}}, 4'h2});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL rm7_as_rne: got %h want %h", observed(), want); end
  endtask

  task automatic test_exp_range();
    int cyc;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd12280, THREES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'd12314, 1'b1, 1'b1, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL overflow: got %h want %h", observed(), want); end

    launch(3'd0, 1'b0, 16'd12253, THREES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'd12287, 1'b1, 1'b0, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL emax_edge: got %h want %h", observed(), want); end

    // -40 + 34 = -6
    launch(3'd0, 1'b0, 16'hFFD8, THREES);
    wait_done(1, cyc);
    want = mk(1'b0, 16'hFFFA, 1'b1, 1'b0, 1'b1, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL underflow: got %h want %h", observed(), want); end
  endtask

  task automatic test_abort();
    int cyc;
    logic seen;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd100, '0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b00 || observed() !== '0) begin
      n_err++; $display("FAIL abort_clear: got busy/done %b data %h want 00 and 0", {busy, done}, observed());
    end
    seen = 1'b0;
    repeat (40) begin
      @(negedge clk);
      seen = seen | done;
    end
    n_vec++;
    if (seen !== 1'b0) begin n_err++; $display("FAIL abort_no_done: got done seen %b want 0", seen); end

    launch(3'd0, 1'b0, 16'd6000, THREES);
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 3) begin n_err++; $display("FAIL after_abort latency: got %0d want 3", cyc); end
    want = mk(1'b0, 16'd6034, 1'b1, 1'b0, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL after_abort: got %h want %h", observed(), want); end
  endtask

  task automatic test_ld_in_shift();
    int cyc;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd1000, {{7{4'h0}}, {61{4'h2}}});
    cyc = 1;
    repeat (2) begin
      @(posedge clk);
      @(negedge clk);
      cyc++;
    end
    rm = 3'd2; sign_i = 1'b1; exp_i = 16'd5; sig_i = NINES; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    cyc++;
    ld = 1'b0;
    wait_done(cyc, cyc);
    n_vec++;
    if (cyc !== 10) begin n_err++; $display("FAIL ld_shift latency: got %0d want 10", cyc); end
    want = mk(1'b0, 16'd1027, 1'b1, 1'b0, 1'b0, {34{4'h2}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL ld_shift: got %h want %h", observed(), want); end
  endtask

  task automatic test_back_to_back();
    int cyc;
    logic [155:0] want;
    launch(3'd0, 1'b0, 16'd6000, THREES);
    wait_done(1, cyc);
    rm = 3'd0; sign_i = 1'b0; exp_i = 16'd6000; sig_i = NINES; ld = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ld = 1'b0;
    n_vec++;
    if ({busy, done} !== 2'b10) begin
      n_err++; $display("FAIL ld_in_done busy: got busy/done %b want 10", {busy, done});
    end
    want = mk(1'b0, 16'd6034, 1'b1, 1'b0, 1'b0, {34{4'h3}});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL hold_outputs: got %h want %h", observed(), want); end
    wait_done(1, cyc);
    n_vec++;
    if (cyc !== 3) begin n_err++; $display("FAIL b2b latency: got %0d want 3", cyc); end
    want = mk(1'b0, 16'd6035, 1'b1, 1'b0, 1'b0, {4'h1, 132'h0});
    n_vec++;
    if (observed() !== want) begin n_err++; $display("FAIL b2b: got %h want %h", observed(), want); end
    @(negedge clk);
    n_vec++;
    if ({busy, done} !== 2'b00) begin
      n_err++; $display("FAIL done_pulse: got busy/done %b want 00", {busy, done});
    end
  endtask

  initial begin
    test_reset();
    test_round_modes();
    test_max_shift();
    test_exp_range();
    test_abort();
    test_ld_in_shift();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/dfp_norm_round128.md
DFP_NORM_ROUND128 -- requirements
Module: dfp_norm_round128

Interface
REQ-001 SHALL have parameter NDIG, default 34, result significand length in BCD digits.
REQ-002 SHALL have parameter EMAXB, default 12287, largest legal biased exponent of the least significant digit (LSD).
REQ-003 clk  input  1  clock; all state changes on rising edge.
REQ-004 rst  input  1  reset, synchronous, active-high.
REQ-005 ld  input  1  load strobe; valid when high for one cycle.
REQ-006 rm  input  3  rounding mode: 0 RNE, 1 RTZ, 2 RTP, 3 RTM, 4 RMM, 5-7 treated as RNE.
REQ-007 sign_i  input  1  sign of the multiplier product.
REQ-008 exp_i  input  16  signed biased exponent of the LSD of sig_i.
REQ-009 sig_i  input  272  68-digit BCD product significand, digit 67 most significant.
REQ-010 busy  output  1  high while an operation is in progress.
REQ-011 done  output  1  one-cycle pulse when results are valid.
REQ-012 sign_o  output  1  result sign.
REQ-013 exp_o  output  16  result biased exponent of the LSD.
REQ-014 sig_o  output  136  34-digit BCD result significand.
REQ-015 inexact, overflow, underflow  output  1 each  status flags.

Function
REQ-016 SHALL implement FSM states IDLE, SHIFT, ROUND, DONE.
REQ-017 IDLE/DONE + ld: SHALL capture rm, sign_i, exp_i and sig_i, clear the shift counter, go to SHIFT.
REQ-018 ld in SHIFT or ROUND SHALL be ignored; busy=1 in SHIFT and ROUND only.
REQ-019 SHIFT: if digit 67 == 0 and count < 34, SHALL shift the working significand left one digit (zero fill) and increment count; otherwise go to ROUND; exactly one digit per cycle.
REQ-020 ROUND: keep = digits 67..34, round digit R = digit 33, sticky S = OR of digits 32..0, inexact = (R != 0) | S.
REQ-021 Increment decision: RNE: R>5, or R==5 and S, or R==5 and !S and keep LSD odd; RTZ: never; RTP: inexact & !sign; RTM: inexact & sign; RMM: R>=5.
REQ-022 Exponent SHALL be exp_i + (34 - count), computed at 17-bit signed width.
REQ-023 Increment SHALL be a full BCD +1 across 34 digits; on carry out of digit 33 (all nines), sig_o = 1 followed by 33 zeros and the exponent +1.
REQ-024 overflow SHALL be set when the final exponent > EMAXB; underflow SHALL be set when it is < 0; exp_o = low 16 bits in both cases; no saturation.
REQ-025 All-zero sig_i SHALL reach count=34 and give sig_o=0, exp_o=exp_i, inexact=0.
REQ-026 ROUND SHALL register all outputs and go to DONE; done=1 only during DONE; DONE with no ld returns to IDLE.
REQ-027 Outputs SHALL hold their values until the next ROUND completes.
REQ-028 Latency: ld sampled at edge t0, k shifts taken -> done high in cycle t0+3+k; minimum 3, maximum 37.
REQ-029 sign_o SHALL equal the captured sign_i unchanged, including zero results.

Reset
REQ-030 rst SHALL force IDLE, busy=0, done=0, and all data outputs and flags to 0; rst has priority over ld.
REQ-031 rst during SHIFT or ROUND SHALL abort the operation with no done pulse.

Verification
REQ-032 sig_i = 14 in the two lowest digits, exp_i=6176, rm=0 -> count caps at 34, sig_o = 14 in the lowest digits, exp_o=6176, inexact=0, done at t0+37.
REQ-033 sig_i = 68 threes, exp_i=6000, rm=0 -> no shift, sig_o = 34 threes, exp_o=6034, inexact=1, done at t0+3; same input with rm=2, sign 0 -> LSD=4.
REQ-034 sig_i = 68 nines, exp_i=6000, rm=0 -> sig_o = 1 then 33 zeros, exp_o=6035, inexact=1.
REQ-035 sig_i = 0, exp_i=100, rm=3, sign 1 -> sig_o=0, exp_o=100, sign_o=1, no flags; sig_i = 68 threes, exp_i=12280 -> overflow=1, exp_o=12314.
REQ-036 rst asserted mid-SHIFT, then a new ld -> no done for the aborted operation, all outputs 0; the new operation completes with correct latency.
REQ-037 ld pulsed during SHIFT -> ignored, first result unaffected; ld in DONE cycle -> accepted, busy=1 next cycle.
